// File: rtl/puc_pkg.sv
// puc_pkg: opcode encoding shared by the PUC decoder and the program sequencer.
//   OPCODE_WIDTH - width of the decoded opcode bus
//   RESET, JUMP, IF0JUMP, IF1JUMP, CALL, RET, RETI - control-flow opcodes
//   NOP          - any code not listed above simply advances the pc
package puc_pkg;

   localparam int OPCODE_WIDTH = 4;

   localparam logic [OPCODE_WIDTH-1:0] NOP     = 4'h0;
   localparam logic [OPCODE_WIDTH-1:0] RESET   = 4'h1;
   localparam logic [OPCODE_WIDTH-1:0] JUMP    = 4'h2;
   localparam logic [OPCODE_WIDTH-1:0] IF0JUMP = 4'h3;
   localparam logic [OPCODE_WIDTH-1:0] IF1JUMP = 4'h4;
   localparam logic [OPCODE_WIDTH-1:0] CALL    = 4'h5;
   localparam logic [OPCODE_WIDTH-1:0] RET     = 4'h6;
   localparam logic [OPCODE_WIDTH-1:0] RETI    = 4'h7;

endpackage

// File: rtl/program_sequencer_return_stack.sv
// return_stack: parametrised LIFO of return addresses.
//   clock    in  rising-edge clock
//   clear    in  synchronous clear of the fill level (contents are kept)
//   push     in  write pushData at the top and increment depth (ignored when full)
//   pop      in  decrement depth (ignored when empty)
//   pushData in  WIDTH-bit entry to push
//   top      out most recent entry, combinational (zero when empty)
//   full     out depth == DEPTH
//   empty    out depth == 0
//   depth    out number of valid entries, registered
module return_stack #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           pushData,
   output logic [WIDTH-1:0]           top,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] depth
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [DW-1:0] DEPTH_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DW-1:0]    depth_q;
   logic [DW-1:0]    depth_d;
   logic [DW-1:0]    top_idx;

   assign full    = (depth_q == DEPTH[DW-1:0]);
   assign empty   = (depth_q == '0);
   assign depth   = depth_q;
   assign top_idx = depth_q - DEPTH_ONE;
   // Read path is combinational so a return completes in a single cycle.
   assign top     = empty ? '0 : mem_q[top_idx[AW-1:0]];

   always_comb begin
      depth_d = depth_q;
      if (clear) begin
         depth_d = '0;
      end else if (push && !full) begin
         depth_d = depth_q + DEPTH_ONE;
      end else if (pop && !empty) begin
         depth_d = depth_q - DEPTH_ONE;
      end
   end

   always_ff @(posedge clock) begin
      depth_q <= depth_d;
   end

   // Storage is deliberately not reset; only the fill level is.
   always_ff @(posedge clock) begin
      if (!clear && push && !full) begin
         mem_q[depth_q[AW-1:0]] <= pushData;
      end
   end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: program counter and return-address sequencer for the PUC CPU.
//   clock            in  sole clock, rising edge
//   resetN           in  synchronous active-low reset
//   opcode           in  decoded opcode (puc_pkg)
//   instructionValue in  jump/call target, low PC_WIDTH bits used, zero-extended
//   registerValue    in  operand tested by IF0JUMP / IF1JUMP
//   stall            in  hold all state this cycle
//   pc               out registered program counter
//   stackDepth       out registered return-stack fill level
//   overflow         out sticky: push attempted with the stack full
//   underflow        out sticky: RET/RETI attempted with the stack empty
// Build option PC_INTERRUPT_EN adds single-level interrupt entry/return:
//   irqRequest       in  level interrupt request
//   irqAck           out one-cycle pulse when the interrupt is taken
//   inInterrupt      out high while the handler runs
module program_sequencer
   import puc_pkg::*;
#(
   parameter int PC_WIDTH       = 8,
   parameter int STACK_DEPTH    = 16,
   parameter int VALUE_WIDTH    = 8,
   parameter int REGISTER_WIDTH = 8,
   parameter int IRQ_VECTOR     = 1
) (
   input  logic                             clock,
   input  logic                             resetN,
   input  logic [OPCODE_WIDTH-1:0]          opcode,
   input  logic [VALUE_WIDTH-1:0]           instructionValue,
   input  logic [REGISTER_WIDTH-1:0]        registerValue,
   input  logic                             stall,
   output logic [PC_WIDTH-1:0]              pc,
   output logic [$clog2(STACK_DEPTH+1)-1:0] stackDepth,
   output logic                             overflow,
   output logic                             underflow
`ifdef PC_INTERRUPT_EN
   ,
   input  logic                             irqRequest,
   output logic                             irqAck,
   output logic                             inInterrupt
`endif
);

   localparam logic [PC_WIDTH-1:0] PC_ONE = 1;
   localparam logic [PC_WIDTH-1:0] IRQ_PC = IRQ_VECTOR[PC_WIDTH-1:0];

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic                in_irq_q, in_irq_d;

   logic [PC_WIDTH-1:0] target;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] stk_top;
   logic [PC_WIDTH-1:0] push_data;
   logic                stk_full, stk_empty;
   logic                push, pop, stk_clear;
   logic                op_reset;
   logic                irq_req, irq_take, irq_blocked;

   generate
      if (VALUE_WIDTH >= PC_WIDTH) begin : g_target_trunc
         assign target = instructionValue[PC_WIDTH-1:0];
      end else begin : g_target_ext
         assign target = {{(PC_WIDTH-VALUE_WIDTH){1'b0}}, instructionValue};
      end
   endgenerate

   // Without the interrupt option the request is tied low; the entry path
   // then folds away and RETI degenerates to RET.
`ifdef PC_INTERRUPT_EN
   assign irq_req = irqRequest;
`else
   assign irq_req = 1'b0;
`endif

   assign pc_inc      = pc_q + PC_ONE;
   assign op_reset    = (opcode == RESET);
   assign stk_clear   = !resetN || op_reset;
   assign irq_take    = irq_req && !in_irq_q && !stk_full;
   assign irq_blocked = irq_req && !in_irq_q && stk_full;

   return_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (PC_WIDTH)
   ) u_stack (
      .clock    (clock),
      .clear    (stk_clear),
      .push     (push),
      .pop      (pop),
      .pushData (push_data),
      .top      (stk_top),
      .full     (stk_full),
      .empty    (stk_empty),
      .depth    (stackDepth)
   );

   always_comb begin
      pc_d      = pc_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      in_irq_d  = in_irq_q;
      push      = 1'b0;
      pop       = 1'b0;
      push_data = pc_inc;
      if (op_reset) begin
         pc_d     = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
         in_irq_d = 1'b0;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (irq_take) begin
         // The instruction at pc is dropped and re-executed after RETI.
         push      = 1'b1;
         push_data = pc_q;
         pc_d      = IRQ_PC;
         in_irq_d  = 1'b1;
      end else begin
         // A request blocked by a full stack keeps waiting while the
         // current instruction proceeds, so a RET can make room.
         if (irq_blocked) begin
            ovf_d = 1'b1;
         end
         case (opcode)
            JUMP:    pc_d = target;
            IF0JUMP: pc_d = (registerValue == '0) ? target : pc_inc;
            IF1JUMP: pc_d = (registerValue != '0) ? target : pc_inc;
            CALL: begin
               if (!stk_full) begin
                  push = 1'b1;
                  pc_d = target;
               end else begin
                  ovf_d = 1'b1;
                  pc_d  = pc_inc;
               end
            end
            RET, RETI: begin
               if (!stk_empty) begin
                  pop  = 1'b1;
                  pc_d = stk_top;
               end else begin
                  unf_d = 1'b1;
                  pc_d  = pc_inc;
               end
               if (opcode == RETI) begin
                  in_irq_d = 1'b0;
               end
            end
            default: pc_d = pc_inc;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         pc_q     <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         in_irq_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         in_irq_q <= in_irq_d;
      end
   end

   assign pc        = pc_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

`ifdef PC_INTERRUPT_EN
   logic irq_ack_q;

   always_ff @(posedge clock) begin
      if (!resetN) begin
         irq_ack_q <= 1'b0;
      end else begin
         irq_ack_q <= !op_reset && !stall && irq_take;
      end
   end

   assign irqAck      = irq_ack_q;
   assign inInterrupt = in_irq_q;
`endif

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised program counter and return-address sequencer for the PUC CPU. It generalises the fixed 16-entry counter: configurable PC width and stack depth, an unconditional jump, a pipeline stall, and stack overflow/underflow detection. Optionally, it adds single-level interrupt entry and return. It sits between the instruction decoder, which supplies the opcode and immediate, and instruction memory, which is addressed by `pc`.

## Interface
- `PC_WIDTH`, 8: program counter width in bits.
- `STACK_DEPTH`, 16: number of return-stack entries; must be ≥2.
- `VALUE_WIDTH`, 8: width of the instruction immediate.
- `REGISTER_WIDTH`, 8: width of the tested register.
- `IRQ_VECTOR`, 1: interrupt entry address, truncated to `PC_WIDTH`. Used only with `PC_INTERRUPT_EN`.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `resetN`  in  1  reset, synchronous and active-low.
- `opcode`  in  OPCODE_WIDTH  decoded instruction opcode.
- `instructionValue`  in  VALUE_WIDTH  jump/call target. Low `PC_WIDTH` bits are used; missing upper bits are zero-extended.
- `registerValue`  in  REGISTER_WIDTH  operand tested by `IF0JUMP`/`IF1JUMP`.
- `stall`  in  1  high: hold all state this cycle.
- `pc`  out  PC_WIDTH  current program counter, registered.
- `stackDepth`  out  $clog2(STACK_DEPTH+1)  number of valid return entries, registered.
- `overflow`  out  1  sticky; a `CALL` or interrupt push was attempted with the stack full.
- `underflow`  out  1  sticky; a `RET`/`RETI` was attempted with the stack empty.
- `irqRequest`  in  1  level interrupt request. Exists only with `PC_INTERRUPT_EN`.
- `irqAck`  out  1  one-cycle pulse when the interrupt is taken. Exists only with `PC_INTERRUPT_EN`.
- `inInterrupt`  out  1  high while the interrupt handler runs. Exists only with `PC_INTERRUPT_EN`.

## Operation
- Priority, highest first: `resetN`=0, then opcode `RESET`, then `stall`, then interrupt entry, then the remaining opcodes.
- `resetN`=0 or `RESET`:
  - `pc`, `stackDepth`, `overflow`, `underflow`, `inInterrupt` and `irqAck` all go to 0.
  - Stack contents are not reset.
- `stall`=1: every register holds and `irqAck`=0.
- `JUMP`: `pc` ← target.
- `IF0JUMP`: `pc` ← target if `registerValue`==0, else `pc`+1.
- `IF1JUMP`: `pc` ← target if `registerValue`≠0, else `pc`+1.
- `CALL`, stack not full: push `pc`+1, `stackDepth`+1, `pc` ← target.
- `CALL`, stack full: no push, `overflow` ← 1, `pc` ← `pc`+1.
- `RET`, stack not empty: `pc` ← top entry, `stackDepth`−1.
- `RET`, stack empty: `underflow` ← 1, `pc` ← `pc`+1.
- Any other opcode: `pc` ← `pc`+1.
- All `pc` arithmetic wraps modulo 2^PC_WIDTH. Incrementing from all-ones gives 0.
- Full means `stackDepth`==`STACK_DEPTH`; empty means `stackDepth`==0. `stackDepth` never leaves 0..`STACK_DEPTH`.
- The sticky flags clear only on reset.

## Timing
- All outputs are registered. An opcode presented in cycle N determines `pc` and `stackDepth` in cycle N+1.
- The return address is read combinationally from the stack top, so `RET` has single-cycle latency.
- A push and the pointer increment happen on the same edge. A `RET` immediately after a `CALL` returns to the `CALL`'s `pc`+1.
- Deasserting `resetN` mid-call-chain discards the chain; the next cycle starts at `pc`=0 with an empty stack.
- A stalled `CALL` or `RET` takes effect on the first unstalled cycle, if still presented.

## Configuration
- `PC_INTERRUPT_EN` defined: interrupt logic and its three ports are compiled in.
  - Interrupt entry condition: `irqRequest`=1, `inInterrupt`=0, not stalled, not in reset.
  - If the stack is not full on entry: push the current `pc`. The instruction at `pc` is discarded and re-executed on return. Then `pc` ← `IRQ_VECTOR`, `inInterrupt` ← 1, `irqAck`=1 for one cycle.
  - If the stack is full on entry: the interrupt waits and `overflow` is set.
  - `RETI`: same as `RET`, plus `inInterrupt` ← 0. An underflowing `RETI` still clears `inInterrupt`.
  - Interrupts do not nest.
- `PC_INTERRUPT_EN` undefined: no interrupt ports exist, and `RETI` behaves exactly as `RET`.

## Structure
- Package `puc_pkg` holds:
  - `OPCODE_WIDTH`;
  - opcode constants `RESET`, `CALL`, `RET`, `RETI`, `JUMP`, `IF0JUMP`, `IF1JUMP`, shared with the decoder.
- Sub-module `return_stack`: parametrised LIFO with `push`, `pop`, `pushData`, `top`, `full`, `empty` and `depth`. Its write and pointer update happen on the same edge.
- `program_sequencer` holds the `pc` register, priority logic, sticky flags and interrupt state.

## Test plan
- `resetN`=0 for one cycle, then `JUMP` 0x20 → `pc`=0 and `stackDepth`=0 during reset; next cycle `pc`=0x20.
- At `pc`=0x10, `CALL` 0x40, then `CALL` 0x60, then `RET`, then `RET`:
  - `pc` sequence 0x40, 0x60, 0x41, 0x11;
  - `stackDepth` sequence 1, 2, 1, 0.
- `STACK_DEPTH`=2, three `CALL`s → third gives `overflow`=1, `pc`=prior+1, `stackDepth`=2. `RET` on an empty stack gives `underflow`=1.
- `IF0JUMP` 0x30 with `registerValue` 0 then 5 → `pc`=0x30, then 0x31. `IF1JUMP` mirrors this. At `pc`=0xFF, a default opcode gives `pc`=0x00.
- `stall`=1 for 3 cycles during a `CALL` → `pc` and `stackDepth` frozen; the `CALL` completes on the first unstalled cycle.
- With `PC_INTERRUPT_EN`, `irqRequest` at `pc`=0x05 → `irqAck` pulse, `pc`=`IRQ_VECTOR`, `inInterrupt`=1, second request ignored. `RETI` → `pc`=0x05, `inInterrupt`=0.
